// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX
  } state_e;

  function automatic logic isDivOp(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic isSignedOp(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Start/done handshake and HI/LO result bus between the control FSM and the mul/div unit.
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic             flush;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, flush, a, b,
                  input  busy, done, div_by_zero, hi, lo);
  modport slave  (input  start, op, flush, a, b,
                  output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate: either hi/lo independently, or {hi,lo} as one 2W value.
module muldiv_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic             negWide_i,
  input  logic             negHi_i,
  input  logic             negLo_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [2*WIDTH-1:0] wideNeg;

  assign wideNeg = ~{hi_i, lo_i} + (2*WIDTH)'(1);

  always_comb begin
    hi_o = negHi_i ? (~hi_i + WIDTH'(1)) : hi_i;
    lo_o = negLo_i ? (~lo_i + WIDTH'(1)) : lo_i;
    if (negWide_i) begin
      {hi_o, lo_o} = wideNeg;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: magnitudes go through a shared radix-2 shift/add
// datapath, signs are restored on the FIX edge, and HI/LO are owned here.
module muldiv_unit import muldiv_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic               signA_q, signA_d, signB_q, signB_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d, dzPulse_q, dzPulse_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   accHi_q, accHi_d, accLo_q, accLo_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  op_e                opIn;
  logic               inSignA, inSignB;
  logic [WIDTH-1:0]   absA, absB, resHi, resLo;
  logic [WIDTH:0]     mulSum, divShift;
  logic               divGe;
  logic [WIDTH-1:0]   divSub;

  assign opIn    = op_e'(bus.op);
  assign inSignA = isSignedOp(opIn) & bus.a[WIDTH-1];
  assign inSignB = isSignedOp(opIn) & bus.b[WIDTH-1];

  muldiv_sign_fix #(.WIDTH(WIDTH)) uOperandFix (
    .negWide_i (1'b0),
    .negHi_i   (inSignA),
    .negLo_i   (inSignB),
    .hi_i      (bus.a),
    .lo_i      (bus.b),
    .hi_o      (absA),
    .lo_o      (absB)
  );

  // Multiply negates the whole product; divide negates quotient and remainder separately.
  muldiv_sign_fix #(.WIDTH(WIDTH)) uResultFix (
    .negWide_i (!isDivOp(op_q) && (signA_q ^ signB_q)),
    .negHi_i   (isDivOp(op_q) && signA_q),
    .negLo_i   (isDivOp(op_q) && (signA_q ^ signB_q)),
    .hi_i      (accHi_q),
    .lo_i      (accLo_q),
    .hi_o      (resHi),
    .lo_o      (resLo)
  );

  assign mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, opnd_q} : '0);
  assign divShift = {accHi_q, accLo_q[WIDTH-1]};
  assign divGe    = divShift >= {1'b0, opnd_q};
  // The true difference is below the divisor, so the low W bits hold it exactly.
  assign divSub   = divShift[WIDTH-1:0] - opnd_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    signA_d   = signA_q;
    signB_d   = signB_q;
    dz_d      = dz_q;
    cnt_d     = cnt_q;
    accHi_d   = accHi_q;
    accLo_d   = accLo_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dzPulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          op_d    = opIn;
          signA_d = inSignA;
          signB_d = inSignB;
          cnt_d   = CNT_W'(WIDTH);
          accHi_d = '0;
          accLo_d = isDivOp(opIn) ? absA : absB;
          opnd_d  = isDivOp(opIn) ? absB : absA;
          dz_d    = isDivOp(opIn) && (bus.b == '0);
          state_d = dz_d ? ST_FIX : ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (isDivOp(op_q)) begin
            accHi_d = divGe ? divSub : divShift[WIDTH-1:0];
            accLo_d = {accLo_q[WIDTH-2:0], divGe};
          end else begin
            accHi_d = mulSum[WIDTH:1];
            accLo_d = {mulSum[0], accLo_q[WIDTH-1:1]};
          end
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_FIX;
          end
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!bus.flush) begin
          done_d    = 1'b1;
          dzPulse_d = dz_q;
          if (!dz_q) begin
            hi_d = resHi;
            lo_d = resLo;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MULT;
      signA_q   <= 1'b0;
      signB_q   <= 1'b0;
      dz_q      <= 1'b0;
      cnt_q     <= '0;
      accHi_q   <= '0;
      accLo_q   <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dzPulse_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      signA_q   <= signA_d;
      signB_q   <= signB_d;
      dz_q      <= dz_d;
      cnt_q     <= cnt_d;
      accHi_q   <= accHi_d;
      accLo_q   <= accLo_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dzPulse_q <= dzPulse_d;
    end
  end

  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dzPulse_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: a 32-bit instance for the main table and
// handshake corner cases, plus an 8-bit instance for the narrow-width divide.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  muldiv_if #(.WIDTH(32)) bus32 ();
  muldiv_if #(.WIDTH(8))  bus8 ();

  muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
  muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge E0.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus32.op    = op;
    bus32.a     = a;
    bus32.b     = b;
    bus32.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus32.start = 1'b0;
    bus32.op    = 2'($urandom_range(0, 3));
    bus32.a     = $urandom;
    bus32.b     = $urandom;
  endtask

  task automatic waitDone(input int limit, output int cycles, output bit busyOk);
    cycles = -1;
    busyOk = (bus32.busy === 1'b1);
    for (int n = 1; n <= limit; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus32.done === 1'b1) begin
        cycles = n;
        return;
      end
      if (bus32.busy !== 1'b1) busyOk = 1'b0;
    end
  endtask

  task automatic watchNoDone(input int span, output bit sawDone);
    sawDone = 1'b0;
    for (int n = 0; n < span; n++) begin
      @(negedge clk);
      if (bus32.done !== 1'b0) sawDone = 1'b1;
    end
  endtask

  vec_t vecs[13];
  int   cycles;
  bit   busyOk;
  bit   sawDone;

  initial begin
    checks   = 0;
    failures = 0;
    vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4]  = '{OP_MULT,  32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000};
    vecs[5]  = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[6]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[7]  = '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
    vecs[8]  = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[9]  = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    vecs[10] = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[11] = '{OP_DIV,   32'h00000005, 32'h00000007, 32'h00000005, 32'h00000000};
    vecs[12] = '{OP_DIV,   32'h80000000, 32'h00000002, 32'h00000000, 32'hC0000000};

    bus32.start = 1'b0; bus32.flush = 1'b0; bus32.op = 2'b00; bus32.a = '0; bus32.b = '0;
    bus8.start  = 1'b0; bus8.flush  = 1'b0; bus8.op  = 2'b00; bus8.a  = '0; bus8.b  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    checkOutput("reset_hi",   64'(bus32.hi), 64'h0);
    checkOutput("reset_lo",   64'(bus32.lo), 64'h0);
    checkOutput("reset_busy", 64'(bus32.busy), 64'h0);
    checkOutput("reset_done", 64'(bus32.done), 64'h0);
    checkOutput("reset_dz",   64'(bus32.div_by_zero), 64'h0);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      waitDone(40, cycles, busyOk);
      checkOutput($sformatf("vec%0d_latency", i), 64'(cycles), 64'd33);
      checkOutput($sformatf("vec%0d_busy_run", i), 64'(busyOk), 64'h1);
      checkOutput($sformatf("vec%0d_busy_done", i), 64'(bus32.busy), 64'h0);
      checkOutput($sformatf("vec%0d_hi", i), 64'(bus32.hi), 64'(vecs[i].expHi));
      checkOutput($sformatf("vec%0d_lo", i), 64'(bus32.lo), 64'(vecs[i].expLo));
      checkOutput($sformatf("vec%0d_dz", i), 64'(bus32.div_by_zero), 64'h0);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_done_pulse", i), 64'(bus32.done), 64'h0);
    end

    // Preload HI/LO, then divide by zero: flag after one edge, HI/LO untouched.
    applyStimulus(OP_MULTU, 32'h12345678, 32'h00000100);
    waitDone(40, cycles, busyOk);
    checkOutput("preload_hi", 64'(bus32.hi), 64'h00000012);
    checkOutput("preload_lo", 64'(bus32.lo), 64'h34567800);
    @(negedge clk);
    applyStimulus(OP_DIVU, 32'h00000007, 32'h00000000);
    waitDone(5, cycles, busyOk);
    checkOutput("dz_latency", 64'(cycles), 64'd1);
    checkOutput("dz_flag",    64'(bus32.div_by_zero), 64'h1);
    checkOutput("dz_hi",      64'(bus32.hi), 64'h00000012);
    checkOutput("dz_lo",      64'(bus32.lo), 64'h34567800);
    @(negedge clk);
    checkOutput("dz_done_pulse", 64'(bus32.done), 64'h0);
    checkOutput("dz_flag_pulse", 64'(bus32.div_by_zero), 64'h0);

    // Start while busy is ignored; flush at E10 aborts with no done.
    applyStimulus(OP_MULT, 32'h00000003, 32'h00000005);
    repeat (4) @(negedge clk);
    bus32.start = 1'b1; bus32.op = OP_DIVU; bus32.a = 32'd100; bus32.b = 32'd3;
    @(negedge clk);
    bus32.start = 1'b0;
    repeat (4) @(negedge clk);
    bus32.flush = 1'b1;
    @(negedge clk);
    bus32.flush = 1'b0;
    checkOutput("flush_busy", 64'(bus32.busy), 64'h0);
    watchNoDone(40, sawDone);
    checkOutput("flush_no_done", 64'(sawDone), 64'h0);
    checkOutput("flush_hi", 64'(bus32.hi), 64'h00000012);
    checkOutput("flush_lo", 64'(bus32.lo), 64'h34567800);

    applyStimulus(OP_MULT, 32'h00000003, 32'h00000005);
    waitDone(40, cycles, busyOk);
    checkOutput("relaunch_latency", 64'(cycles), 64'd33);
    checkOutput("relaunch_hi", 64'(bus32.hi), 64'h0);
    checkOutput("relaunch_lo", 64'(bus32.lo), 64'hF);

    // New start accepted in the done cycle.
    applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'h00000002);
    checkOutput("b2b_done_low", 64'(bus32.done), 64'h0);
    checkOutput("b2b_busy", 64'(bus32.busy), 64'h1);
    waitDone(40, cycles, busyOk);
    checkOutput("b2b_latency", 64'(cycles), 64'd33);
    checkOutput("b2b_hi", 64'(bus32.hi), 64'hFFFFFFFF);
    checkOutput("b2b_lo", 64'(bus32.lo), 64'hFFFFFFFD);
    @(negedge clk);

    // Start and flush together in IDLE: nothing launches.
    bus32.start = 1'b1; bus32.flush = 1'b1; bus32.op = OP_MULTU; bus32.a = 32'd9; bus32.b = 32'd9;
    @(negedge clk);
    bus32.start = 1'b0; bus32.flush = 1'b0;
    checkOutput("startflush_busy", 64'(bus32.busy), 64'h0);
    watchNoDone(40, sawDone);
    checkOutput("startflush_no_done", 64'(sawDone), 64'h0);
    checkOutput("startflush_lo", 64'(bus32.lo), 64'hFFFFFFFD);

    // Asynchronous reset mid-RUN.
    applyStimulus(OP_MULT, 32'h00000003, 32'h00000005);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_busy", 64'(bus32.busy), 64'h0);
    checkOutput("arst_hi",   64'(bus32.hi), 64'h0);
    checkOutput("arst_lo",   64'(bus32.lo), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // WIDTH=8: DIVU 200/7.
    bus8.op = OP_DIVU; bus8.a = 8'd200; bus8.b = 8'd7; bus8.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0; bus8.a = 8'hA5; bus8.b = 8'h00;
    cycles = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus8.done === 1'b1) begin
        cycles = n;
        break;
      end
    end
    checkOutput("w8_latency", 64'(cycles), 64'd9);
    checkOutput("w8_hi", 64'(bus8.hi), 64'd4);
    checkOutput("w8_lo", 64'(bus8.lo), 64'd28);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
